// File: rtl/regfile_mp.sv
// regfile_mp: multi-port register file, 2 prioritised write ports,
// RP sync read ports, optional zero r0, optional forwarding, busy scoreboard.
//
// Ports:
//   clk, rst (async, active-low)
//   rd_en/rd_addr -> rd_data/rd_busy : RP registered read ports
//   wa_*, wb_*   : write ports, B wins on address clash
//   rsv_en/addr  : mark register pending; busy is the pending vector
module regfile_mp #(
  parameter int N       = 32,
  parameter int M       = 3,
  parameter int RP      = 2,
  parameter int ZERO_R0 = 1,
  parameter int FWD     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [RP-1:0]     rd_en,
  input  logic [RP*M-1:0]   rd_addr,
  output logic [RP*N-1:0]   rd_data,
  output logic [RP-1:0]     rd_busy,
  input  logic              wa_en,
  input  logic [M-1:0]      wa_addr,
  input  logic [N-1:0]      wa_data,
  input  logic              wb_en,
  input  logic [M-1:0]      wb_addr,
  input  logic [N-1:0]      wb_data,
  input  logic              rsv_en,
  input  logic [M-1:0]      rsv_addr,
  output logic [(1<<M)-1:0] busy
);

  localparam int D = 1 << M;

  logic [N-1:0] regs [D];
  logic [D-1:0] wa_hit;
  logic [D-1:0] wb_hit;
  logic [D-1:0] rsv_hit;
  logic [D-1:0] busy_nxt;

  // Per-register decode; r0 is masked out entirely when hardwired.
  always_comb begin
    wa_hit  = '0;
    wb_hit  = '0;
    rsv_hit = '0;
    for (int i = 0; i < D; i++) begin
      wa_hit[i]  = wa_en  && (wa_addr  == M'(i));
      wb_hit[i]  = wb_en  && (wb_addr  == M'(i));
      rsv_hit[i] = rsv_en && (rsv_addr == M'(i));
    end
    if (ZERO_R0 != 0) begin
      wa_hit[0]  = 1'b0;
      wb_hit[0]  = 1'b0;
      rsv_hit[0] = 1'b0;
    end
  end

  // A reserve beats a completing write: the new producer owns the reg.
  assign busy_nxt = rsv_hit | (busy & ~wa_hit & ~wb_hit);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      busy <= '0;
    end else begin
      busy <= busy_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < D; i++) begin
        regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < D; i++) begin
        if (wb_hit[i]) begin
          regs[i] <= wb_data;
        end else if (wa_hit[i]) begin
          regs[i] <= wa_data;
        end
      end
    end
  end

  for (genvar k = 0; k < RP; k++) begin : g_rd
    logic [M-1:0] a;
    logic [N-1:0] val;
    logic [N-1:0] q;
    logic         b;

    assign a = rd_addr[k*M +: M];

    always_comb begin
      val = regs[a];
      if (FWD != 0) begin
        if (wb_hit[a]) begin
          val = wb_data;
        end else if (wa_hit[a]) begin
          val = wa_data;
        end
      end
      if ((ZERO_R0 != 0) && (a == '0)) begin
        val = '0;
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q <= '0;
        b <= 1'b0;
      end else if (rd_en[k]) begin
        q <= val;
        b <= busy_nxt[a];
      end
    end

    assign rd_data[k*N +: N] = q;
    assign rd_busy[k]        = b;
  end

endmodule
